// File: rtl/matmul_ctrl.sv
// matmul_ctrl -- sequencing controller for the N x N matrix-multiply datapath.
//
// Walks every result element C[i][j] in row-major order. Per element: clear
// the MAC accumulator, issue N operand address pairs, let the last product
// land, strobe the final data register, write C and collect resultIsInvalid.
//
// Parameters
//   N           matrix dimension (2..15)
//   ADDR_WIDTH  operand/result address width, 2**ADDR_WIDTH >= N*N
//
// Ports
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   start          begin a multiply (sampled only in IDLE)
//   abort          synchronous cancel, honoured in every state
//   result_invalid resultIsInvalid from the final data register (WRITE cycle)
//   busy           high in every state except IDLE
//   done           one-cycle completion pulse
//   addr_a/addr_b  operand read addresses i*N+k / k*N+j (0 outside ISSUE)
//   mac_clr        clear accumulator
//   mac_en         accumulate current operand product (issue delayed by 1)
//   en_FDReg       final data register capture strobe
//   wr_en/addr_c   C memory write strobe / address i*N+j (0 outside WRITE)
//   err_any        sticky: at least one element was invalid in this run
//   err_cnt        saturating invalid-element count
//
// Build option
//   MATMUL_CTRL_ERRCNT_EN  when defined, err_cnt counts invalid elements;
//                          otherwise err_cnt is tied to 0.

module matmul_ctrl #(
    parameter int N          = 3,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  result_invalid,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] addr_a,
    output logic [ADDR_WIDTH-1:0] addr_b,
    output logic                  mac_clr,
    output logic                  mac_en,
    output logic                  en_FDReg,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] addr_c,
    output logic                  err_any,
    output logic [ADDR_WIDTH:0]   err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ISSUE,
        S_DRAIN,
        S_CAPTURE,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] DIM  = ADDR_WIDTH'(N);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(N - 1);

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] i;
    logic [ADDR_WIDTH-1:0] j;
    logic [ADDR_WIDTH-1:0] k;
    logic                  issuing;
    logic                  writing;
    logic                  accept;

    assign issuing = (state == S_ISSUE);
    assign writing = (state == S_WRITE);
    assign accept  = (state == S_IDLE) && start && !abort;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:    if (start) state_next = S_CLEAR;
            S_CLEAR:   state_next = S_ISSUE;
            S_ISSUE:   if (k == LAST) state_next = S_DRAIN;
            S_DRAIN:   state_next = S_CAPTURE;
            S_CAPTURE: state_next = S_WRITE;
            S_WRITE:   state_next = (i == LAST && j == LAST) ? S_DONE : S_CLEAR;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
        // abort wins over everything, including start in IDLE
        if (abort) begin
            state_next = S_IDLE;
        end
    end

    // Element / operand indices
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i <= '0;
            j <= '0;
            k <= '0;
        end else if (abort && state != S_IDLE) begin
            i <= '0;
            j <= '0;
            k <= '0;
        end else begin
            unique case (state)
                S_CLEAR: k <= '0;
                S_ISSUE: k <= k + 1'b1;
                S_WRITE: begin
                    if (j == LAST) begin
                        j <= '0;
                        i <= i + 1'b1;
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                S_DONE: begin
                    i <= '0;
                    j <= '0;
                end
                default: ;
            endcase
        end
    end

    // Operand data arrives one cycle after its address, so the accumulate
    // strobe trails the issue phase by one register stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mac_en <= 1'b0;
        end else begin
            mac_en <= issuing && !abort;
        end
    end

    // Sticky error flag: cleared when a run is accepted, held across abort.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_any <= 1'b0;
        end else if (accept) begin
            err_any <= 1'b0;
        end else if (writing && !abort && result_invalid) begin
            err_any <= 1'b1;
        end
    end

`ifdef MATMUL_CTRL_ERRCNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt <= '0;
        end else if (accept) begin
            err_cnt <= '0;
        end else if (writing && !abort && result_invalid && err_cnt != '1) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
`else
    assign err_cnt = '0;
`endif

    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);
    assign mac_clr  = (state == S_CLEAR);
    assign en_FDReg = (state == S_CAPTURE);
    assign wr_en    = writing;
    assign addr_a   = issuing ? (i * DIM + k) : '0;
    assign addr_b   = issuing ? (k * DIM + j) : '0;
    assign addr_c   = writing ? (i * DIM + j) : '0;

endmodule

// File: tb/tb_matmul_ctrl.sv
// Self-checking bench for matmul_ctrl (N=3, ADDR_WIDTH=4).
module tb_matmul_ctrl;

    localparam int N  = 3;
    localparam int AW = 4;
    localparam int NN = N * N;
    localparam int EL = N + 4;
    localparam int T  = NN * EL;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic          abort;
    logic          result_invalid;
    logic          busy;
    logic          done;
    logic [AW-1:0] addr_a;
    logic [AW-1:0] addr_b;
    logic          mac_clr;
    logic          mac_en;
    logic          en_FDReg;
    logic          wr_en;
    logic [AW-1:0] addr_c;
    logic          err_any;
    logic [AW:0]   err_cnt;

    matmul_ctrl #(
        .N          (N),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .abort          (abort),
        .result_invalid (result_invalid),
        .busy           (busy),
        .done           (done),
        .addr_a         (addr_a),
        .addr_b         (addr_b),
        .mac_clr        (mac_clr),
        .mac_en         (mac_en),
        .en_FDReg       (en_FDReg),
        .wr_en          (wr_en),
        .addr_c         (addr_c),
        .err_any        (err_any),
        .err_cnt        (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int sb[$];
    int exp_any  = 0;
    int exp_cnt  = 0;

    typedef struct {
        logic start;
        logic abort;
        logic busy;
        logic mac_clr;
        logic mac_en;
        int   addr_a;
        int   addr_b;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic e_busy, input logic e_done,
                              input logic e_clr, input logic e_mac, input logic e_fd,
                              input logic e_wr, input int ea, input int eb, input int ec);
        chk({tag, " busy"},     busy,     e_busy);
        chk({tag, " done"},     done,     e_done);
        chk({tag, " mac_clr"},  mac_clr,  e_clr);
        chk({tag, " mac_en"},   mac_en,   e_mac);
        chk({tag, " en_FDReg"}, en_FDReg, e_fd);
        chk({tag, " wr_en"},    wr_en,    e_wr);
        chk({tag, " addr_a"},   addr_a,   ea);
        chk({tag, " addr_b"},   addr_b,   eb);
        chk({tag, " addr_c"},   addr_c,   ec);
    endtask

    task automatic check_err(input string tag);
        chk({tag, " err_any"}, err_any, exp_any);
`ifdef MATMUL_CTRL_ERRCNT_EN
        chk({tag, " err_cnt"}, err_cnt, exp_cnt);
`else
        chk({tag, " err_cnt"}, err_cnt, 0);
`endif
    endtask

    // One multiply run from IDLE. Expected outputs come from the per-element
    // timeline: CLEAR, ISSUE x N, DRAIN, CAPTURE, WRITE, then DONE at T+1.
    task automatic run(input logic [NN-1:0] inv, input int abort_at,
                       input int noise_at, input int exp_left);
        int dones;
        sb.delete();
        for (int e = 0; e < NN; e++) sb.push_back(e);
        start          = 1'b1;
        abort          = 1'b0;
        result_invalid = 1'b0;
        exp_any        = 0;
        exp_cnt        = 0;
        tick();
        start = 1'b0;
        dones = 0;
        for (int c = 1; c <= T + 3; c++) begin
            string tag;
            bit    live;
            int    e, p, kk, ii, jj;
            tag  = $sformatf("c%0d", c);
            live = (abort_at == 0) || (c <= abort_at);
            e    = (c - 1) / EL;
            p    = (c - 1) % EL;
            kk   = p - 1;
            ii   = e / N;
            jj   = e % N;
            if (!live || c > T + 1) begin
                check_outs(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            end else if (c == T + 1) begin
                check_outs(tag, 1, 1, 0, 0, 0, 0, 0, 0, 0);
            end else begin
                check_outs(tag, 1, 0, p == 0, (p >= 2 && p <= N + 1), p == N + 2, p == N + 3,
                           (p >= 1 && p <= N) ? ii * N + kk : 0,
                           (p >= 1 && p <= N) ? kk * N + jj : 0,
                           (p == N + 3) ? e : 0);
            end
            check_err(tag);
            if (wr_en === 1'b1) begin
                chk({tag, " sb nonempty"}, sb.size() > 0, 1);
                if (sb.size() > 0) chk({tag, " sb addr_c"}, addr_c, sb.pop_front());
            end
            if (done === 1'b1) dones++;
            // stimulus for the current cycle
            if (live && c <= T && p == N + 3) result_invalid = inv[e];
            else                              result_invalid = 1'b0;
            abort = (c == abort_at);
            start = (c == noise_at);
            if (result_invalid) begin
                exp_any = 1;
                if (exp_cnt < (1 << (AW + 1)) - 1) exp_cnt++;
            end
            tick();
        end
        result_invalid = 1'b0;
        abort          = 1'b0;
        start          = 1'b0;
        chk("done pulses", dones, (abort_at == 0) ? 1 : 0);
        chk("sb left", sb.size(), exp_left);
        sb.delete();
    endtask

    initial begin
        // start/abort control vectors from IDLE
        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0}; // start+abort: stay IDLE
        tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0}; // CLEAR
        tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0}; // ISSUE k=0, start ignored
        tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1, 3}; // ISSUE k=1
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0}; // abort -> IDLE, mac_en off
        tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0}; // restart from element 0
        tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0};

        reset_n        = 1'b1;
        start          = 1'b0;
        abort          = 1'b0;
        result_invalid = 1'b0;
        #3 reset_n = 1'b0;
        #1;
        check_outs("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_err("reset");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check_outs("post-reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int v = 0; v < 8; v++) begin
            string tag;
            tag   = $sformatf("vec%0d", v);
            start = tbl[v].start;
            abort = tbl[v].abort;
            tick();
            chk({tag, " busy"},    busy,    tbl[v].busy);
            chk({tag, " mac_clr"}, mac_clr, tbl[v].mac_clr);
            chk({tag, " mac_en"},  mac_en,  tbl[v].mac_en);
            chk({tag, " addr_a"},  addr_a,  tbl[v].addr_a);
            chk({tag, " addr_b"},  addr_b,  tbl[v].addr_b);
            chk({tag, " done"},    done,    0);
        end
        start = 1'b0;
        abort = 1'b0;
        tick();

        // clean run, with a stray start while busy
        run('0, 0, 20, 0);
        // invalid results on elements 4 and 7
        run(NN'(9'b010010000), 0, 0, 0);
        // next start clears the error summary
        run('0, 0, 0, 0);
        // abort during ISSUE of element 5 (cycle 37), errors held
        run(NN'(9'b000010000), 37, 0, 4);
        tick();
        run('0, 0, 0, 0);

        // asynchronous reset during CAPTURE of element 0
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 2; c <= 6; c++) tick();
        chk("pre-reset en_FDReg", en_FDReg, 1);
        #2 reset_n = 1'b0;
        #1;
        exp_any = 0;
        exp_cnt = 0;
        check_outs("async reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_err("async reset");
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_outs($sformatf("idle%0d", c), 0, 0, 0, 0, 0, 0, 0, 0, 0);
        end
        run('0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
